irq_request_unit: RTL and testbench
===================================

Name: irq_request_unit

Overview:
Parametrised successor to the 8-line IRQ request latch used in the 8259-style PIC. It synchronises N_IRQ asynchronous request lines and latches them into an interrupt request register (IRR), with a per-channel edge or level mode. It masks requests with the IMR, resolves priority against the in-service register (ISR) and raises int_req. It runs the two-strobe acknowledge sequence that yields the vector index, and retires ISR bits on EOI. It sits between the external IR pins and the control/vector-output logic.

Parameters:
N_IRQ, 8, number of request channels (2..32)
SYNC_STAGES, 2, synchroniser flops per irq line (>=2)
IDX_W (localparam), $clog2(N_IRQ), width of the vector index

Ports:
clk  input  1  system clock, all state rising-edge
rst_n  input  1  asynchronous active-low reset
irq_lines  input  N_IRQ  asynchronous request pins
trig_mode  input  N_IRQ  per-channel mode: 0 = edge, 1 = level
imr  input  N_IRQ  mask, 1 = channel masked
ack_first  input  1  single-cycle strobe for the first INTA
ack_second  input  1  single-cycle strobe for the second INTA
eoi  input  1  single-cycle non-specific end-of-interrupt
int_req  output  1  interrupt request to the CPU
vector_idx  output  IDX_W  acknowledged channel index
vector_valid  output  1  one-cycle pulse; vector_idx valid
spurious  output  1  high with vector_valid when no request won at ack_first
irr  output  N_IRQ  request register
isr  output  N_IRQ  in-service register

Behaviour:
- Reset (async, rst_n=0):
  - Synchronisers, irr, isr, vector_idx, vector_valid, spurious and int_req all 0.
  - FSM goes to IDLE; the priority pointer is 0 (channel 0 highest).
- Synchroniser: the last sync stage is s[i]; an extra flop holds s_d[i]. A line rising is visible in irr on the (SYNC_STAGES+1)th clk edge.
- Edge mode: irr[i] is set when s[i] & ~s_d[i]. It is cleared when s[i]=0, or when the channel is granted at ack_first. A set and a clear in the same cycle resolve to clear.
- Level mode: irr[i] = s[i] every cycle. There is no clear at ack.
- Priority:
  - Default order is index 0 highest.
  - cand = highest-priority bit of irr & ~imr.
  - top_isr = highest-priority bit of isr.
- int_req is a registered output, asserted in IDLE when cand exists and ranks above top_isr (fully nested mode). It drops one cycle after the condition drops.
- FSM IDLE:
  - On ack_first, freeze cand into win_idx and move to WAIT2.
  - If a candidate exists: isr[win_idx] <= 1, apply the edge-mode irr clear, int_req <= 0.
  - If no candidate: win_idx = N_IRQ-1, spurious_pending = 1, isr is unchanged.
- FSM WAIT2:
  - int_req is held at 0; a repeated ack_first is ignored.
  - On ack_second: vector_idx <= win_idx, vector_valid = 1 for one cycle, spurious = spurious_pending for the same cycle; go to IDLE.
- ack_second while in IDLE: ignored, no pulse.
- eoi, any state: clears the highest-priority set bit of isr. If isr = 0, no effect.
  - eoi in the same cycle as ack_first: the clear is evaluated on the pre-update isr, then the new bit is set.
- Changes to imr or trig_mode take effect on the next cycle. A trig_mode change does not clear irr.
- rst_n asserted mid-sequence: immediate return to IDLE with all state cleared; no vector_valid is issued.

Optional Feature:
ROTATE_PRIORITY_EN.
- Defined: each eoi that clears isr bit k sets the priority pointer to (k+1) mod N_IRQ. Priority order then starts at the pointer and wraps.
- Undefined: the pointer is held at 0 and priority is fixed, index 0 highest. The rotation logic is absent.

Test Plan:
- Reset, then raise irq_lines[3] in edge mode -> irr[3]=1 after 3 clocks (SYNC_STAGES=2), then int_req=1. ack_first -> isr=8'h08, irr[3]=0. ack_second -> vector_idx=3, vector_valid pulses 1 cycle.
- Lines 5 and 2 rise in the same cycle with imr=0 -> the first acknowledge yields vector_idx=2. While isr[2]=1, line 5 gets no int_req; eoi -> int_req=1 and the next acknowledge yields 5.
- Level mode on channel 6: the line drops before ack_first -> irr[6]=0, and the acknowledge gives spurious=1, vector_idx=7, isr unchanged.
- imr[1]=1 with line 1 high -> int_req stays 0. Clearing imr[1] -> int_req=1 two cycles later (one cycle for imr to take effect, one for the registered output).
- Assert rst_n=0 between ack_first and ack_second -> isr=0, no vector_valid; ack_second after reset is ignored.
- With ROTATE_PRIORITY_EN: eoi retiring channel 2 -> pointer=3. Lines 0 and 4 both requesting -> vector_idx=4 is acknowledged first.

Source files
------------

// File: rtl/irq_request_unit.sv
// Parametrised IRQ request unit: synchronises request pins, latches IRR, resolves priority against ISR, runs the two-strobe INTA sequence.
// Define ROTATE_PRIORITY_EN to enable rotating priority, where EOI moves the pointer past the retired channel.
module irq_request_unit #(
  parameter  int unsigned N_IRQ       = 8,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned IDX_W       = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_lines,
  input  logic [N_IRQ-1:0] trig_mode,
  input  logic [N_IRQ-1:0] imr,
  input  logic             ack_first,
  input  logic             ack_second,
  input  logic             eoi,
  output logic             int_req,
  output logic [IDX_W-1:0] vector_idx,
  output logic             vector_valid,
  output logic             spurious,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr
);

  typedef enum logic {IDLE, WAIT2} state_t;

  state_t            state_q, state_d;
  logic [N_IRQ-1:0]  sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0]  s, s_d, imr_q, mode_q;
  logic [N_IRQ-1:0]  req, req_rot, isr_rot;
  logic [N_IRQ-1:0]  grant_vec, eoi_vec, edge_next, irr_d;
  logic [IDX_W-1:0]  cand_rank, top_rank, cand_idx, top_idx;
  logic [IDX_W-1:0]  win_q, win_d;
  logic              spur_q, spur_d;
  logic              cand_ok, isr_any, higher;
  logic              grant, vec_load, int_req_d;

  function automatic logic [IDX_W-1:0] lowest(input logic [N_IRQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = N_IRQ; i > 0; i--)
      if (v[i-1]) r = IDX_W'(i-1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d    <= '0;
      imr_q  <= '0;
      mode_q <= '0;
    end else begin
      sync_q[0] <= irq_lines;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d    <= sync_q[SYNC_STAGES-1];
      imr_q  <= imr;
      mode_q <= trig_mode;
    end
  end

  assign s   = sync_q[SYNC_STAGES-1];
  assign req = irr & ~imr_q;

`ifdef ROTATE_PRIORITY_EN
  // Priority is resolved in "rank" space (vectors rotated so the pointer is bit 0), then mapped back to a channel index.
  logic [IDX_W-1:0]   ptr;
  logic [2*N_IRQ-1:0] req_dbl, isr_dbl;
  logic [IDX_W:0]     cand_sum, top_sum;

  assign req_dbl = {req, req};
  assign isr_dbl = {isr, isr};
  assign req_rot = req_dbl[ptr +: N_IRQ];
  assign isr_rot = isr_dbl[ptr +: N_IRQ];

  always_comb begin
    cand_sum = {1'b0, cand_rank} + {1'b0, ptr};
    top_sum  = {1'b0, top_rank} + {1'b0, ptr};
    if (cand_sum >= (IDX_W+1)'(N_IRQ)) cand_sum = cand_sum - (IDX_W+1)'(N_IRQ);
    if (top_sum >= (IDX_W+1)'(N_IRQ))  top_sum  = top_sum - (IDX_W+1)'(N_IRQ);
    cand_idx = cand_sum[IDX_W-1:0];
    top_idx  = top_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (eoi && isr_any)
      ptr <= (top_idx == IDX_W'(N_IRQ-1)) ? '0 : top_idx + 1'b1;
  end
`else
  assign req_rot  = req;
  assign isr_rot  = isr;
  assign cand_idx = cand_rank;
  assign top_idx  = top_rank;
`endif

  assign cand_ok   = |req;
  assign isr_any   = |isr;
  assign cand_rank = lowest(req_rot);
  assign top_rank  = lowest(isr_rot);
  assign higher    = !isr_any || (cand_rank < top_rank);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    spur_d    = spur_q;
    grant     = 1'b0;
    vec_load  = 1'b0;
    int_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ack_first) begin
          state_d = WAIT2;
          grant   = cand_ok;
          win_d   = cand_ok ? cand_idx : IDX_W'(N_IRQ-1);
          spur_d  = !cand_ok;
        end else begin
          int_req_d = cand_ok && higher;
        end
      end
      WAIT2: begin
        if (ack_second) begin
          vec_load = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_q        <= '0;
      spur_q       <= 1'b0;
      int_req      <= 1'b0;
      vector_idx   <= '0;
      vector_valid <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      spur_q       <= spur_d;
      int_req      <= int_req_d;
      vector_valid <= vec_load;
      spurious     <= vec_load & spur_q;
      if (vec_load) vector_idx <= win_q;
    end
  end

  assign grant_vec = grant ? (N_IRQ'(1) << cand_idx) : '0;
  assign eoi_vec   = (eoi && isr_any) ? (N_IRQ'(1) << top_idx) : '0;
  // Edge channels: clear (line low or grant) dominates a same-cycle set.
  assign edge_next = (irr | (s & ~s_d)) & s & ~grant_vec;
  assign irr_d     = (mode_q & s) | (~mode_q & edge_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr <= '0;
      isr <= '0;
    end else begin
      irr <= irr_d;
      isr <= (isr & ~eoi_vec) | grant_vec;
    end
  end

endmodule

// File: tb/tb_irq_request_unit.sv
// Scoreboard bench for irq_request_unit: a cycle-level reference model predicts IRR/ISR/int_req and acknowledge vectors.
// Build with ROTATE_PRIORITY_EN defined to exercise the rotating-priority model as well.
module tb_irq_request_unit;
  localparam int N  = 8;
  localparam int SS = 2;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_lines = '0, trig_mode = '0, imr = '0;
  logic          ack_first = 1'b0, ack_second = 1'b0, eoi = 1'b0;
  logic          int_req, vector_valid, spurious;
  logic [IW-1:0] vector_idx;
  logic [N-1:0]  irr, isr;

  irq_request_unit #(.N_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .irq_lines(irq_lines), .trig_mode(trig_mode), .imr(imr),
    .ack_first(ack_first), .ack_second(ack_second), .eoi(eoi), .int_req(int_req),
    .vector_idx(vector_idx), .vector_valid(vector_valid), .spurious(spurious),
    .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit spur; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [N-1:0] hist [SS+1];
  logic [N-1:0] m_irr, m_isr, m_imr, m_mode;
  bit           m_int, m_busy, m_spur;
  int           m_win, m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void find_first(input logic [N-1:0] v, input int ptr,
                                     output bit found, output int idx, output int rank);
    found = 0; idx = 0; rank = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (!found && v[j]) begin found = 1; idx = j; rank = k; end
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= SS; k++) hist[k] = '0;
    m_irr = '0; m_isr = '0; m_imr = '0; m_mode = '0;
    m_int = 0; m_busy = 0; m_spur = 0; m_win = 0; m_ptr = 0;
  endtask

  task automatic model_update();
    logic [N-1:0] s, sd, n_irr, n_isr;
    bit cf, tf, n_int;
    int ci, cr, ti, tr, grant, n_ptr;
    if (!rst_n) begin model_reset(); return; end
    s  = hist[SS-1];
    sd = hist[SS];
    find_first(m_irr & ~m_imr, m_ptr, cf, ci, cr);
    find_first(m_isr, m_ptr, tf, ti, tr);
    n_isr = m_isr; n_int = 0; grant = -1; n_ptr = m_ptr;
    if (eoi && tf) begin
      n_isr[ti] = 1'b0;
`ifdef ROTATE_PRIORITY_EN
      n_ptr = (ti + 1) % N;
`endif
    end
    if (!m_busy) begin
      if (ack_first) begin
        m_busy = 1;
        if (cf) begin grant = ci; n_isr[ci] = 1'b1; m_win = ci; m_spur = 0; end
        else    begin m_win = N - 1; m_spur = 1; end
      end else begin
        n_int = cf && (!tf || cr < tr);
      end
    end else if (ack_second) begin
      exp_q.push_back('{m_win, m_spur});
      m_busy = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])                   n_irr[i] = s[i];
      else if (!s[i] || i == grant)    n_irr[i] = 1'b0;
      else if (!sd[i])                 n_irr[i] = 1'b1;
      else                             n_irr[i] = m_irr[i];
    end
    for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = irq_lines;
    m_imr = imr; m_mode = trig_mode;
    m_irr = n_irr; m_isr = n_isr; m_int = n_int; m_ptr = n_ptr;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("irr", 32'(irr), 32'(m_irr));
    check("isr", 32'(isr), 32'(m_isr));
    check("int_req", 32'(int_req), 32'(m_int));
    #1;
  endtask

  // Monitor: pops one expected vector per vector_valid pulse
  always @(negedge clk) begin
    if (vector_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vector", 32'(vector_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("vector_idx", 32'(vector_idx), 32'(e.idx));
        check("spurious", 32'(spurious), 32'(e.spur));
      end
    end else if (spurious) begin
      check("spurious_no_valid", 32'(spurious), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    step();
    check("rst_vector_valid", 32'(vector_valid), 32'd0);
    check("rst_irr", 32'(irr), 32'd0);
    step();
    rst_n = 1'b1;

    // Edge request on line 3 through a full acknowledge
    irq_lines[3] = 1'b1;
    step(); step();
    check("irr3_early", 32'(irr[3]), 32'd0);
    step();
    check("irr3_after3", 32'(irr[3]), 32'd1);
    step();
    check("int_req_line3", 32'(int_req), 32'd1);
    ack_first = 1'b1; step(); ack_first = 1'b0;
    check("isr_after_ack", 32'(isr), 32'h08);
    check("irr3_cleared", 32'(irr[3]), 32'd0);
    ack_second = 1'b1; step(); ack_second = 1'b0;
    step();
    eoi = 1'b1; step(); eoi = 1'b0;
    irq_lines = '0; step(); step();

    // Simultaneous lines 5 and 2
    irq_lines = N'((1 << 5) | (1 << 2));
    repeat (4) step();
    ack_first = 1'b1; step(); ack_first = 1'b0;
    ack_second = 1'b1; step(); ack_second = 1'b0;
    step(); step();
    check("nested_block", 32'(int_req), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    check("int_req_after_eoi", 32'(int_req), 32'd1);
    ack_first = 1'b1; step(); ack_first = 1'b0;
    ack_second = 1'b1; step(); ack_second = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    irq_lines = '0; repeat (3) step();

    // Level channel 6 withdraws before acknowledge
    trig_mode[6] = 1'b1; irq_lines[6] = 1'b1;
    repeat (4) step();
    irq_lines[6] = 1'b0;
    repeat (3) step();
    check("irr6_dropped", 32'(irr[6]), 32'd0);
    ack_first = 1'b1; step(); ack_first = 1'b0;
    check("isr_spurious", 32'(isr), 32'd0);
    ack_second = 1'b1; step(); ack_second = 1'b0;
    trig_mode = '0; step();

    // Masked line 1, then unmask; reset mid-sequence
    imr[1] = 1'b1; irq_lines[1] = 1'b1;
    repeat (5) step();
    check("masked_int", 32'(int_req), 32'd0);
    imr[1] = 1'b0; step();
    check("unmask_1cyc", 32'(int_req), 32'd0);
    step();
    check("unmask_2cyc", 32'(int_req), 32'd1);
    ack_first = 1'b1; step(); ack_first = 1'b0;
    rst_n = 1'b0; step();
    check("isr_mid_reset", 32'(isr), 32'd0);
    rst_n = 1'b1;
    ack_second = 1'b1; step(); ack_second = 1'b0;
    irq_lines = '0; repeat (4) step();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) irq_lines[i] = ~irq_lines[i];
      if ($urandom_range(0, 99) < 3) trig_mode = N'($urandom);
      if ($urandom_range(0, 99) < 3) imr = N'($urandom & $urandom);
      ack_first  = (!m_busy && m_int && $urandom_range(0, 2) == 0) || ($urandom_range(0, 39) == 0);
      ack_second = (m_busy && $urandom_range(0, 2) == 0) || ($urandom_range(0, 29) == 0);
      eoi        = (m_isr != '0 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 599) != 0);
      step();
    end
    ack_first = 1'b0; ack_second = 1'b0; eoi = 1'b0; rst_n = 1'b1;
    repeat (4) step();
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
